// File: rtl/cache_pkg.sv
// Shared constants, state type and byte-lane helper for the cache line refill path.
package cache_pkg;

    localparam int LINE_BYTES = 8;
    localparam int OFFSET_W   = 3;
    localparam int LINE_W     = 64;
    localparam int LANE_W     = LINE_W / LINE_BYTES;

    typedef enum logic [1:0] {
        IDLE,
        WB,
        FILL,
        DONE
    } refill_state_t;

    function automatic logic [LANE_W-1:0] byte_lane(input logic [LINE_W-1:0]   line,
                                                    input logic [OFFSET_W-1:0] idx);
        return line[idx*LANE_W +: LANE_W];
    endfunction

endpackage

// File: rtl/refill_beat_ctr.sv
// Beat counter shared by the writeback and fill phases: loadable start offset,
// wrapping increment, and a done flag raised by the increment that completes a line.
module refill_beat_ctr
    import cache_pkg::*;
#(
    parameter int W = OFFSET_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] start,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic [W-1:0] next_cnt,
    output logic         done
);

    // Beats completed since the last load; independent of the wrapping offset.
    logic [W-1:0] beats;

    always_comb begin
        next_cnt = cnt;
        if (load)
            next_cnt = start;
        else if (inc)
            next_cnt = cnt + 1'b1;
    end

    assign done = inc & (beats == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            beats <= '0;
        end else if (load) begin
            cnt   <= start;
            beats <= '0;
        end else if (inc) begin
            cnt   <= cnt + 1'b1;
            beats <= beats + 1'b1;
        end
    end

endmodule

// File: rtl/cache_line_refill.sv
// Line transfer engine: optional dirty-victim writeback then a byte-beat line fill.
// Define CACHE_REFILL_CWF_EN to start the fill at the requested byte (critical word first).
module cache_line_refill
    import cache_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int BYTE_W = 8,
    parameter int BEATS  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_fill_addr,
    input  logic                     req_wb,
    input  logic [ADDR_W-1:0]        req_wb_addr,
    input  logic [BEATS*BYTE_W-1:0]  req_wb_data,
    output logic                     resp_valid,
    output logic [BEATS*BYTE_W-1:0]  resp_data,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [BYTE_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    input  logic [BYTE_W-1:0]        mem_rdata,
    output logic                     busy
);

    refill_state_t              state;
    logic [ADDR_W-OFFSET_W-1:0] fill_base;
    logic [ADDR_W-OFFSET_W-1:0] wb_base;
    logic [OFFSET_W-1:0]        fill_start;
    logic [LINE_W-1:0]          wb_line;
    logic [LINE_W-1:0]          line_buf;
    logic [LINE_W-1:0]          line_next;

    logic                accept;
    logic                beat_ack;
    logic [OFFSET_W-1:0] start_off;
    logic                ctr_load;
    logic [OFFSET_W-1:0] ctr_start;
    logic [OFFSET_W-1:0] ctr_cnt;
    logic [OFFSET_W-1:0] ctr_next;
    logic                ctr_done;
    logic                unused_bits;

`ifdef CACHE_REFILL_CWF_EN
    assign start_off   = req_fill_addr[OFFSET_W-1:0];
    assign unused_bits = ^req_wb_addr[OFFSET_W-1:0];
`else
    assign start_off   = '0;
    assign unused_bits = ^{req_wb_addr[OFFSET_W-1:0], req_fill_addr[OFFSET_W-1:0]};
`endif

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = req_valid & req_ready;
    assign beat_ack  = mem_req & mem_ack;

    // The counter is reloaded with the fill start on the last writeback ack,
    // so the fill begins on the very next cycle without a bubble.
    assign ctr_load  = accept | ((state == WB) & ctr_done);
    assign ctr_start = (state == IDLE) ? (req_wb ? '0 : start_off) : fill_start;

    refill_beat_ctr #(.W(OFFSET_W)) u_beat_ctr (
        .clk      (clk),
        .rst      (rst),
        .load     (ctr_load),
        .start    (ctr_start),
        .inc      (beat_ack),
        .cnt      (ctr_cnt),
        .next_cnt (ctr_next),
        .done     (ctr_done)
    );

    always_comb begin
        line_next = line_buf;
        line_next[ctr_cnt*BYTE_W +: BYTE_W] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            fill_base  <= '0;
            wb_base    <= '0;
            fill_start <= '0;
            wb_line    <= '0;
            line_buf   <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        fill_base  <= req_fill_addr[ADDR_W-1:OFFSET_W];
                        wb_base    <= req_wb_addr[ADDR_W-1:OFFSET_W];
                        fill_start <= start_off;
                        wb_line    <= req_wb_data;
                        mem_req    <= 1'b1;
                        if (req_wb) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {req_wb_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                            mem_wdata <= byte_lane(req_wb_data, '0);
                        end else begin
                            state     <= FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {req_fill_addr[ADDR_W-1:OFFSET_W], start_off};
                            mem_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (beat_ack) begin
                        if (ctr_done) begin
                            state     <= FILL;
                            mem_we    <= 1'b0;
                            mem_addr  <= {fill_base, fill_start};
                            mem_wdata <= '0;
                        end else begin
                            mem_addr  <= {wb_base, ctr_next};
                            mem_wdata <= byte_lane(wb_line, ctr_next);
                        end
                    end
                end
                FILL: begin
                    if (beat_ack) begin
                        line_buf <= line_next;
                        if (ctr_done) begin
                            state      <= DONE;
                            mem_req    <= 1'b0;
                            mem_addr   <= '0;
                            resp_valid <= 1'b1;
                            resp_data  <= line_next;
                        end else begin
                            mem_addr <= {fill_base, ctr_next};
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_line_refill.sv
// Randomized bench for cache_line_refill against a line-level memory/beat-order model.
module tb_cache_line_refill;
    import cache_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_fill_addr;
    logic        req_wb;
    logic [31:0] req_wb_addr;
    logic [63:0] req_wb_data;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        busy;

    cache_line_refill #(.ADDR_W(32), .BYTE_W(8), .BEATS(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_fill_addr (req_fill_addr),
        .req_wb        (req_wb),
        .req_wb_addr   (req_wb_addr),
        .req_wb_data   (req_wb_data),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] fill_addr;
        logic        wb;
        logic [31:0] wb_addr;
        logic [63:0] wb_data;
    } req_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [7:0]  data;
    } beat_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  mem_model [logic [31:0]];
    int          last_lat;
    logic [63:0] last_resp;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return a[7:0];
    endfunction

    task automatic drive_req(input req_t r, input logic v);
        req_valid     = v;
        req_fill_addr = r.fill_addr;
        req_wb        = r.wb;
        req_wb_addr   = r.wb_addr;
        req_wb_data   = r.wb_data;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.fill_addr = 32'h4000 + {$urandom_range(0, 7), 3'b000} + $urandom_range(0, 7);
        r.wb        = $urandom_range(0, 1);
        r.wb_addr   = 32'h4000 + {$urandom_range(0, 7), 3'b000} + $urandom_range(0, 7);
        r.wb_data   = {$urandom, $urandom};
        return r;
    endfunction

    // mode: 0 = always ack, 1 = directed stall, 2 = random ack; abort_beat >= 0 resets mid-fill.
    task automatic run_req(input req_t r, input int mode, input int stall_beat, input int stall_len,
                           input int abort_beat, input bit hold, input req_t nxt);
        beat_t       exp_q[$];
        beat_t       bt;
        logic [63:0] exp_line;
        logic [31:0] a;
        int          start, cycles, stalls, done_beats, stall_cnt, nbeats;
        bit          finished, aborted, ack;

        start = 0;
`ifdef CACHE_REFILL_CWF_EN
        start = int'(r.fill_addr % 8);
`endif
        if (r.wb) begin
            for (int i = 0; i < 8; i++) begin
                a  = {r.wb_addr[31:3], 3'b000} + i;
                bt = '{we: 1'b1, addr: a, data: r.wb_data[8*i +: 8]};
                exp_q.push_back(bt);
                mem_model[a] = r.wb_data[8*i +: 8];
            end
        end
        exp_line = '0;
        for (int k = 0; k < 8; k++) begin
            int b;
            b  = (start + k) % 8;
            a  = {r.fill_addr[31:3], 3'b000} + b;
            bt = '{we: 1'b0, addr: a, data: 8'h00};
            exp_q.push_back(bt);
            exp_line[8*b +: 8] = mem_read(a);
        end
        nbeats = exp_q.size();

        drive_req(r, 1'b1);
        check_val("ready_idle", req_ready, 1);
        check_val("busy_idle", busy, 0);
        @(negedge clk);
        if (hold)
            drive_req(nxt, 1'b1);
        else
            drive_req(rand_req(), 1'b0);

        cycles = 1; stalls = 0; done_beats = 0; stall_cnt = 0;
        finished = 0; aborted = 0;
        while (!finished && cycles < 300) begin
            if (resp_valid) begin
                check_val("resp_early", exp_q.size(), 0);
                check_val("req_at_resp", mem_req, 0);
                check_val("resp_data", resp_data, exp_line);
                check_val("latency", cycles, nbeats + stalls + 1);
                last_lat  = cycles;
                last_resp = resp_data;
                finished  = 1;
            end else if (exp_q.size() == 0) begin
                check_val("resp_missing", resp_valid, 1);
                finished = 1;
            end else begin
                check_val("ready_busy", {req_ready, busy}, 2'b01);
                check_val("mem_req", mem_req, 1);
                check_val("mem_addr", mem_addr, exp_q[0].addr);
                check_val("mem_we", mem_we, exp_q[0].we);
                if (exp_q[0].we)
                    check_val("mem_wdata", mem_wdata, exp_q[0].data);
                if (abort_beat >= 0 && done_beats == abort_beat) begin
                    mem_ack = 1'b0;
                    #2 rst = 1'b1;
                    #1;
                    check_val("abort_outs", {req_ready, busy, resp_valid, mem_req, mem_we},
                              5'b10000);
                    check_val("abort_bus", {mem_addr, mem_wdata}, 0);
                    check_val("abort_resp_data", resp_data, 0);
                    @(negedge clk);
                    rst = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(negedge clk);
                        check_val("abort_quiet", {resp_valid, mem_req, req_ready}, 3'b001);
                    end
                    finished = 1;
                    aborted  = 1;
                end else begin
                    case (mode)
                        0: ack = 1'b1;
                        1: ack = !(done_beats == stall_beat && stall_cnt < stall_len);
                        default: ack = ($urandom_range(0, 3) != 0);
                    endcase
                    if (!ack && mode == 1)
                        stall_cnt++;
                    mem_ack   = ack;
                    mem_rdata = ack ? mem_read(mem_addr) : 8'($urandom);
                    if (ack) begin
                        void'(exp_q.pop_front());
                        done_beats++;
                    end else begin
                        stalls++;
                    end
                end
            end
            if (!finished) begin
                @(negedge clk);
                cycles++;
            end
        end
        if (!finished)
            check_val("timeout", 0, 1);
        mem_ack = 1'b0;
        if (!aborted)
            @(negedge clk);
    endtask

    req_t r, r2, cur, nxt;

    initial begin
        rst = 1'b1;
        req_valid = 1'b0; req_fill_addr = '0; req_wb = 1'b0; req_wb_addr = '0; req_wb_data = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check_val("rst_ctrl", {req_ready, busy, resp_valid, mem_req, mem_we}, 5'b10000);
        check_val("rst_bus", {mem_addr, mem_wdata}, 0);
        check_val("rst_resp_data", resp_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        r = '{fill_addr: 32'h0000_1238, wb: 1'b0, wb_addr: 32'h0, wb_data: 64'h0};
        run_req(r, 0, -1, 0, -1, 1'b0, r);
        check_val("t1_lat", last_lat, 9);
        check_val("t1_line", last_resp, 64'h3F3E3D3C3B3A3938);

        r2 = '{fill_addr: 32'h0000_1238, wb: 1'b1, wb_addr: 32'h0000_2005,
               wb_data: 64'h8877665544332211};
        run_req(r2, 0, -1, 0, -1, 1'b0, r2);
        check_val("t2_lat", last_lat, 17);
        check_val("t2_line", last_resp, 64'h3F3E3D3C3B3A3938);

        run_req(r, 1, 2, 4, -1, 1'b0, r);
        check_val("t3_lat", last_lat, 13);
        check_val("t3_line", last_resp, 64'h3F3E3D3C3B3A3938);

        r2 = '{fill_addr: 32'h0000_123D, wb: 1'b0, wb_addr: 32'h0, wb_data: 64'h0};
        run_req(r2, 0, -1, 0, -1, 1'b0, r2);
        check_val("t4_line", last_resp, 64'h3F3E3D3C3B3A3938);

        r2 = '{fill_addr: 32'h0000_3010, wb: 1'b0, wb_addr: 32'h0, wb_data: 64'h0};
        run_req(r2, 0, -1, 0, 5, 1'b0, r2);
        run_req(r, 0, -1, 0, -1, 1'b0, r);
        check_val("t5_line", last_resp, 64'h3F3E3D3C3B3A3938);

        r2 = '{fill_addr: 32'h0000_2000, wb: 1'b1, wb_addr: 32'h0000_5000,
               wb_data: 64'hCAFE_F00D_1234_5678};
        run_req(r, 0, -1, 0, -1, 1'b1, r2);
        run_req(r2, 0, -1, 0, -1, 1'b0, r2);
        check_val("t6_line", last_resp, 64'h8877665544332211);

        cur = rand_req();
        for (int i = 0; i < 40; i++) begin
            nxt = rand_req();
            run_req(cur, 2, -1, 0, -1, 1'($urandom_range(0, 1)), nxt);
            cur = nxt;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
